// File: rtl/display_pkg.sv
// Shared definitions for the display-sharing arbiter.
// Contents:
//   arb_state_t       : arbiter states ARB_IDLE / ARB_BLANK / ARB_SHOW
//   DIGITS/HEX_W/LUM_W: widths of the seven-segment driver inputs
//   MASK_ALL          : digit mask that blanks all four digits
package display_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BLANK = 2'd1,
    ARB_SHOW  = 2'd2
  } arb_state_t;

  localparam int DIGITS = 4;
  localparam int HEX_W  = 16;
  localparam int LUM_W  = 4;

  localparam logic [DIGITS-1:0] MASK_ALL = 4'hF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set search.
// Ports:
//   req     in  NREQ  request bits
//   ptr     in  PW    index where the search starts (wraps around)
//   exclude in  NREQ  bits to ignore in the search
//   valid   out 1     some non-excluded request bit is set
//   index   out PW    first set, non-excluded bit at or after ptr
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic [NREQ-1:0] exclude,
  output logic            valid,
  output logic [PW-1:0]   index
);

  logic [NREQ-1:0] cand;
  logic [PW-1:0]   sel;

  assign cand = req & ~exclude;

  // Walk from the farthest offset down to ptr itself so the closest
  // candidate to ptr is the last one written and therefore wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel = PW'((int'(ptr) + k) % NREQ);
      if (cand[sel]) begin
        valid = 1'b1;
        index = sel;
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Shares one 4-digit seven-segment driver among NREQ requesters.
// Round-robin ownership with a minimum on-screen time, and a blanking gap
// between owners so multiplexed digits never show mixed content.
// Optional build macro: DISPLAY_ARB_FADE_EN (luminance fades in on each
// new owner, one step every FADE_STEP cycles).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req             per-requester request level
//   req_hexx/mask/points/luminance  per-requester display slices
//   gnt             one-hot grant (or zero)
//   disp_en/hexx/mask/points/luminance  registered driver inputs
module display_share_arbiter
  import display_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int HOLD_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 64,
  parameter int FADE_STEP    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [HEX_W*NREQ-1:0]   req_hexx,
  input  logic [DIGITS*NREQ-1:0]  req_mask,
  input  logic [DIGITS*NREQ-1:0]  req_points,
  input  logic [LUM_W*NREQ-1:0]   req_luminance,
  output logic [NREQ-1:0]         gnt,
  output logic                    disp_en,
  output logic [HEX_W-1:0]        disp_hexx,
  output logic [DIGITS-1:0]       disp_mask,
  output logic [DIGITS-1:0]       disp_points,
  output logic [LUM_W-1:0]        disp_luminance
);

  localparam int PW    = $clog2(NREQ);
  localparam int MAXC  = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

  arb_state_t       state, next_state;
  logic [PW-1:0]    owner, next_owner, ptr, next_ptr, owner_inc;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [NREQ-1:0]  owner_hot, next_hot;
  logic             others;
  logic [PW-1:0]    pick_ptr, pick_idx;
  logic [NREQ-1:0]  pick_excl;
  logic             pick_vld;
  logic [LUM_W-1:0] lum_tgt;

  assign owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign owner_hot = NREQ'(1) << owner;
  assign next_hot  = NREQ'(1) << next_owner;
  assign others    = |(req & ~owner_hot);
  assign lum_tgt   = req_luminance[LUM_W*next_owner +: LUM_W];

  // From SHOW the search starts after the departing owner and skips it, so
  // a waiter always goes before the owner re-acquiring the display.
  assign pick_ptr  = (state == ARB_SHOW) ? owner_inc : ptr;
  assign pick_excl = (state == ARB_SHOW) ? owner_hot : '0;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .exclude (pick_excl),
    .valid   (pick_vld),
    .index   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      owner <= next_owner;
      ptr   <= next_ptr;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_owner = owner;
    next_ptr   = ptr;
    next_cnt   = cnt;
    unique case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          next_owner = pick_idx;
          next_cnt   = BLANK_LOAD;
          next_state = ARB_BLANK;
        end
      end
      ARB_BLANK: begin
        if (cnt != '0) begin
          next_cnt = cnt - 1'b1;
        end else if (req[owner]) begin
          next_cnt   = HOLD_LOAD;
          next_state = ARB_SHOW;
        end else if (pick_vld) begin
          next_owner = pick_idx;
          next_cnt   = BLANK_LOAD;
        end else begin
          next_state = ARB_IDLE;
        end
      end
      ARB_SHOW: begin
        if (cnt != '0) next_cnt = cnt - 1'b1;
        if (!req[owner] || (cnt == '0 && others)) begin
          next_ptr = owner_inc;
          if (pick_vld) begin
            next_owner = pick_idx;
            next_cnt   = BLANK_LOAD;
            next_state = ARB_BLANK;
          end else begin
            next_state = ARB_IDLE;
          end
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Outputs are registered against the post-update state so gnt and
  // disp_en always change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      disp_en     <= 1'b0;
      disp_hexx   <= '0;
      disp_mask   <= MASK_ALL;
      disp_points <= '0;
    end else if (next_state == ARB_SHOW) begin
      gnt         <= next_hot;
      disp_en     <= 1'b1;
      disp_hexx   <= req_hexx[HEX_W*next_owner +: HEX_W];
      disp_mask   <= req_mask[DIGITS*next_owner +: DIGITS];
      disp_points <= req_points[DIGITS*next_owner +: DIGITS];
    end else begin
      gnt         <= '0;
      disp_en     <= 1'b0;
      disp_mask   <= MASK_ALL;
    end
  end

`ifdef DISPLAY_ARB_FADE_EN
  localparam int FW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  logic [FW-1:0] fade_cnt;

  // Fade-in restarts at zero for every new owner; a lowered target snaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_luminance <= '0;
      fade_cnt       <= '0;
    end else if (next_state == ARB_SHOW) begin
      if (state != ARB_SHOW) begin
        disp_luminance <= '0;
        fade_cnt       <= '0;
      end else if (lum_tgt < disp_luminance) begin
        disp_luminance <= lum_tgt;
        fade_cnt       <= '0;
      end else if (lum_tgt != disp_luminance) begin
        if (fade_cnt == FW'(FADE_STEP - 1)) begin
          disp_luminance <= disp_luminance + 1'b1;
          fade_cnt       <= '0;
        end else begin
          fade_cnt <= fade_cnt + 1'b1;
        end
      end
    end
  end
`else
  // FADE_STEP only matters to the fade build.
  logic unused_fade_step;
  assign unused_fade_step = (FADE_STEP != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_luminance <= '0;
    end else if (next_state == ARB_SHOW) begin
      disp_luminance <= lum_tgt;
    end
  end
`endif

endmodule

// File: tb/tb_display_share_arbiter.sv
// Self-checking bench for display_share_arbiter (NREQ=3, BLANK=4, HOLD=8).
module tb_display_share_arbiter;

  localparam int NREQ = 3;

  logic        clk, rst;
  logic [2:0]  req;
  logic [15:0] hx [3];
  logic [3:0]  mk [3];
  logic [3:0]  pt [3];
  logic [3:0]  lm [3];
  logic [47:0] req_hexx;
  logic [11:0] req_mask, req_points, req_luminance;
  logic [2:0]  gnt;
  logic        disp_en;
  logic [15:0] disp_hexx;
  logic [3:0]  disp_mask, disp_points, disp_luminance;

  assign req_hexx      = {hx[2], hx[1], hx[0]};
  assign req_mask      = {mk[2], mk[1], mk[0]};
  assign req_points    = {pt[2], pt[1], pt[0]};
  assign req_luminance = {lm[2], lm[1], lm[0]};

  display_share_arbiter #(
    .NREQ(NREQ), .HOLD_CYCLES(8), .BLANK_CYCLES(4), .FADE_STEP(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_hexx(req_hexx), .req_mask(req_mask), .req_points(req_points),
    .req_luminance(req_luminance),
    .gnt(gnt), .disp_en(disp_en), .disp_hexx(disp_hexx), .disp_mask(disp_mask),
    .disp_points(disp_points), .disp_luminance(disp_luminance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  req;
    logic [15:0] h1;
    logic [2:0]  gnt;
    logic        en;
    logic [15:0] hexx;
    logic [3:0]  mask;
    logic [3:0]  lum;
  } vec_t;

  vec_t vt [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Counts consecutive sampled cycles with gnt == g, bounded by limit.
  task automatic count_while(input logic [2:0] g, input int limit, output int n);
    n = 0;
    while (gnt === g && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int n;
  logic [2:0] order [4];
  logic [3:0] fade_exp [10];

  initial begin
    rst = 1'b1; req = '0;
    hx[0] = 16'h0A0A; hx[1] = 16'h0000; hx[2] = 16'hC2C2;
    mk[0] = 4'h1; mk[1] = 4'h2; mk[2] = 4'h4;
    pt[0] = 4'h3; pt[1] = 4'h5; pt[2] = 4'h6;
    lm[0] = 4'h7; lm[1] = 4'h9; lm[2] = 4'hB;

    vt[0]  = '{3'b010, 16'h1234, 3'b000, 1'b0, 16'h0000, 4'hF, 4'h0};
    vt[1]  = '{3'b010, 16'h1234, 3'b000, 1'b0, 16'h0000, 4'hF, 4'h0};
    vt[2]  = '{3'b010, 16'h1234, 3'b000, 1'b0, 16'h0000, 4'hF, 4'h0};
    vt[3]  = '{3'b010, 16'h1234, 3'b000, 1'b0, 16'h0000, 4'hF, 4'h0};
    vt[4]  = '{3'b010, 16'h1234, 3'b010, 1'b1, 16'h1234, 4'h2, 4'h9};
    vt[5]  = '{3'b010, 16'h5678, 3'b010, 1'b1, 16'h5678, 4'h2, 4'h9};
    vt[6]  = '{3'b010, 16'h9ABC, 3'b010, 1'b1, 16'h9ABC, 4'h2, 4'h9};
    vt[7]  = '{3'b010, 16'h0F0F, 3'b010, 1'b1, 16'h0F0F, 4'h2, 4'h9};
    vt[8]  = '{3'b010, 16'h1111, 3'b010, 1'b1, 16'h1111, 4'h2, 4'h9};
    vt[9]  = '{3'b010, 16'h2222, 3'b010, 1'b1, 16'h2222, 4'h2, 4'h9};
    vt[10] = '{3'b010, 16'h3333, 3'b010, 1'b1, 16'h3333, 4'h2, 4'h9};
    vt[11] = '{3'b010, 16'h4444, 3'b010, 1'b1, 16'h4444, 4'h2, 4'h9};
    vt[12] = '{3'b010, 16'hDEAD, 3'b010, 1'b1, 16'hDEAD, 4'h2, 4'h9};
    vt[13] = '{3'b000, 16'hBEEF, 3'b000, 1'b0, 16'hDEAD, 4'hF, 4'h9};
    vt[14] = '{3'b000, 16'hBEEF, 3'b000, 1'b0, 16'hDEAD, 4'hF, 4'h9};

    // Reset state
    step(); step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_en", 32'(disp_en), 32'h0);
    check("rst_hexx", 32'(disp_hexx), 32'h0);
    check("rst_mask", 32'(disp_mask), 32'hF);
    check("rst_points", 32'(disp_points), 32'h0);
    check("rst_lum", 32'(disp_luminance), 32'h0);
    rst = 1'b0;

    // Single requester, cycle by cycle
    for (int i = 0; i < 15; i++) begin
      req = vt[i].req;
      hx[1] = vt[i].h1;
      step();
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
      check($sformatf("vec%0d_en", i), 32'(disp_en), 32'(vt[i].en));
      check($sformatf("vec%0d_hexx", i), 32'(disp_hexx), 32'(vt[i].hexx));
      check($sformatf("vec%0d_mask", i), 32'(disp_mask), 32'(vt[i].mask));
`ifndef DISPLAY_ARB_FADE_EN
      check($sformatf("vec%0d_lum", i), 32'(disp_luminance), 32'(vt[i].lum));
`endif
    end

    // Preemption: req0 owns, req2 arrives at SHOW cycle 3
    do_reset();
    req = 3'b001;
    count_while(3'b000, 20, n);
    check("pre_latency", 32'(n), 32'd5);
    check("pre_gnt0", 32'(gnt), 32'b001);
    check("pre_points0", 32'(disp_points), 32'h3);
    step(); step();
    req = 3'b101;
    count_while(3'b001, 20, n);
    check("pre_hold_rest", 32'(n), 32'd6);
    check("pre_blank_en", 32'(disp_en), 32'h0);
    check("pre_blank_mask", 32'(disp_mask), 32'hF);
    count_while(3'b000, 20, n);
    check("pre_blank_len", 32'(n), 32'd4);
    check("pre_gnt2", 32'(gnt), 32'b100);
    check("pre_en2", 32'(disp_en), 32'h1);
    check("pre_hexx2", 32'(disp_hexx), 32'hC2C2);
    check("pre_mask2", 32'(disp_mask), 32'h4);
    check("pre_points2", 32'(disp_points), 32'h6);

    // Round-robin with all three requesting
    do_reset();
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    req = 3'b111;
    count_while(3'b000, 20, n);
    check("rr_latency", 32'(n), 32'd5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr%0d_gnt", i), 32'(gnt), 32'(order[i]));
      count_while(order[i], 20, n);
      check($sformatf("rr%0d_show_len", i), 32'(n), 32'd8);
      if (i < 3) begin
        count_while(3'b000, 20, n);
        check($sformatf("rr%0d_blank_len", i), 32'(n), 32'd4);
      end
    end

    // Early drop with no waiters
    do_reset();
    req = 3'b010;
    count_while(3'b000, 20, n);
    check("drop_latency", 32'(n), 32'd5);
    step();
    check("drop_gnt_show", 32'(gnt), 32'b010);
    req = 3'b000;
    step();
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_en", 32'(disp_en), 32'h0);
    check("drop_mask", 32'(disp_mask), 32'hF);
    step();
    check("drop_idle_gnt", 32'(gnt), 32'h0);
    req = 3'b010;
    count_while(3'b000, 20, n);
    check("drop_regrant_latency", 32'(n), 32'd5);

    // Reset during SHOW of owner 2 (ptr not zero at that point)
    do_reset();
    req = 3'b101;
    count_while(3'b000, 20, n);
    count_while(3'b001, 20, n);
    check("mid_hold0", 32'(n), 32'd8);
    count_while(3'b000, 20, n);
    check("mid_gnt2", 32'(gnt), 32'b100);
    step(); step();
    rst = 1'b1;
    step();
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_en", 32'(disp_en), 32'h0);
    check("mid_rst_hexx", 32'(disp_hexx), 32'h0);
    check("mid_rst_mask", 32'(disp_mask), 32'hF);
    rst = 1'b0;
    count_while(3'b000, 20, n);
    check("mid_regrant_latency", 32'(n), 32'd5);
    check("mid_regrant_gnt", 32'(gnt), 32'b001);

`ifdef DISPLAY_ARB_FADE_EN
    // Fade-in at FADE_STEP=2 towards luminance 3, then snap down to 1
    fade_exp[0] = 4'd0; fade_exp[1] = 4'd0; fade_exp[2] = 4'd1; fade_exp[3] = 4'd1;
    fade_exp[4] = 4'd2; fade_exp[5] = 4'd2; fade_exp[6] = 4'd3; fade_exp[7] = 4'd3;
    fade_exp[8] = 4'd3; fade_exp[9] = 4'd3;
    do_reset();
    lm[0] = 4'd3;
    req = 3'b001;
    count_while(3'b000, 20, n);
    check("fade_latency", 32'(n), 32'd5);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("fade%0d", i), 32'(disp_luminance), 32'(fade_exp[i]));
      step();
    end
    lm[0] = 4'd1;
    step();
    check("fade_snap", 32'(disp_luminance), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
